instr_encoder_loader: RTL and testbench

Packs decoded ARM instruction fields into 32-bit instruction words and streams them into instruction memory through a write port. Its field interface and 5-bit internal opcode code match the instruction decoder's outputs. A testbench or boot controller can therefore build programs field-by-field, and the decoder can be checked by round-trip. It sits between a program source and the instruction memory write port.

---
 rtl/instr_encoder_loader.sv | 148 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs decoded ARM instruction fields into words and streams them to instruction memory
module instr_encoder_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              last,
    input  logic [3:0]        cond,
    input  logic [4:0]        opcode,
    input  logic [3:0]        rn,
    input  logic [3:0]        rd,
    input  logic [11:0]       shifterVals,
    input  logic              immediateOperand,
    input  logic              CPSRwrite,
    input  logic              prePostAddOffset,
    input  logic              upDownOffset,
    input  logic              byteOrWord,
    input  logic              writeBack,
    input  logic              loadStore,
    input  logic              linkBit,
    input  logic [23:0]       branchImmediate,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              err_opcode,
    output logic              err_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_MAX   = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr;
    logic              accept;
    logic              op_dp, op_ls, op_br, op_valid;
    logic              overflow_hit;
    logic              prog_end;
    logic [31:0]       enc;

    assign op_dp    = ~opcode[4];
    assign op_ls    = (opcode == 5'b10000);
    assign op_br    = (opcode == 5'b10001);
    assign op_valid = op_dp | op_ls | op_br;

    assign accept       = in_valid & in_ready;
    // A valid word landing on the top address ends the program even without last.
    assign overflow_hit = accept & op_valid & ~last & (ptr == PTR_MAX);
    assign prog_end     = accept & (last | overflow_hit);
    assign busy         = (state == LOAD);

    always_comb begin
        enc = 32'h0;
        if (op_dp) begin
            enc = {cond, 2'b00, immediateOperand, opcode[3:0], CPSRwrite, rn, rd, shifterVals};
        end else if (op_ls) begin
            enc = {cond, 2'b01, immediateOperand, prePostAddOffset, upDownOffset,
                   byteOrWord, writeBack, loadStore, rn, rd, shifterVals};
        end else if (op_br) begin
            enc = {cond, 3'b101, linkBit, branchImmediate};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = LOAD;
            end
            LOAD: begin
                in_ready = ~start;
                if (start) begin
                    state_nx = LOAD;
                end else if (prog_end) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) state_nx = LOAD;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr          <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= 32'h0;
            done         <= 1'b0;
            word_count   <= '0;
            err_opcode   <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            if (start) begin
                ptr          <= start_addr;
                word_count   <= '0;
                err_opcode   <= 1'b0;
                err_overflow <= 1'b0;
            end else if (accept) begin
                if (op_valid) begin
                    wr_en   <= 1'b1;
                    wr_addr <= ptr;
                    wr_data <= enc;
                    ptr     <= ptr + PTR_ONE;
                    if (word_count != COUNT_MAX) begin
                        word_count <= word_count + COUNT_ONE;
                    end
                end else begin
                    err_opcode <= 1'b1;
                end
                if (overflow_hit) begin
                    err_overflow <= 1'b1;
                end
                if (prog_end) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - randomized bench for instr_encoder_loader against a field-arithmetic model
module tb_instr_encoder_loader;

    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          last = 1'b0;
    logic [3:0]    cond = '0, rn = '0, rd = '0;
    logic [4:0]    opcode = '0;
    logic [11:0]   shifterVals = '0;
    logic          immediateOperand = 0, CPSRwrite = 0, prePostAddOffset = 0, upDownOffset = 0;
    logic          byteOrWord = 0, writeBack = 0, loadStore = 0, linkBit = 0;
    logic [23:0]   branchImmediate = '0;
    logic          wr_en, busy, done, err_opcode, err_overflow;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [AW:0]   word_count;

    int checks = 0;
    int failures = 0;

    // reference model state
    bit        m_loading = 0, m_eop = 0, m_eov = 0;
    int        m_ptr = 0, m_cnt = 0;
    bit        e_wr, e_done, e_ready;
    int        e_addr;
    logic [31:0] e_data;
    logic      obs_ready;
    logic [50:0] obs, exp_v;

    instr_encoder_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .in_valid(in_valid), .in_ready(in_ready), .last(last), .cond(cond),
        .opcode(opcode), .rn(rn), .rd(rd), .shifterVals(shifterVals),
        .immediateOperand(immediateOperand), .CPSRwrite(CPSRwrite),
        .prePostAddOffset(prePostAddOffset), .upDownOffset(upDownOffset),
        .byteOrWord(byteOrWord), .writeBack(writeBack), .loadStore(loadStore),
        .linkBit(linkBit), .branchImmediate(branchImmediate),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .done(done), .word_count(word_count), .err_opcode(err_opcode),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_encode();
        longint w;
        w = longint'(cond) * (64'd1 << 28);
        if (opcode < 16) begin
            w += immediateOperand * (64'd1 << 25) + longint'(opcode) * (64'd1 << 21)
               + CPSRwrite * (64'd1 << 20) + longint'(rn) * 65536 + longint'(rd) * 4096
               + longint'(shifterVals);
        end else if (opcode == 16) begin
            w += (64'd1 << 26) + immediateOperand * (64'd1 << 25)
               + prePostAddOffset * (64'd1 << 24) + upDownOffset * (64'd1 << 23)
               + byteOrWord * (64'd1 << 22) + writeBack * (64'd1 << 21)
               + loadStore * (64'd1 << 20) + longint'(rn) * 65536 + longint'(rd) * 4096
               + longint'(shifterVals);
        end else begin
            w += 5 * (64'd1 << 25) + linkBit * (64'd1 << 24) + longint'(branchImmediate);
        end
        return w[31:0];
    endfunction

    task automatic rand_fields();
        cond = 4'($urandom); rn = 4'($urandom); rd = 4'($urandom);
        shifterVals = 12'($urandom); branchImmediate = 24'($urandom);
        {immediateOperand, CPSRwrite, prePostAddOffset, upDownOffset} = 4'($urandom);
        {byteOrWord, writeBack, loadStore, linkBit} = 4'($urandom);
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: opcode = 5'($urandom_range(0, 15));
            6, 7:             opcode = 5'd16;
            8:                opcode = 5'd17;
            default:          opcode = 5'($urandom_range(18, 31));
        endcase
        start = 0; in_valid = 1; last = 0;
    endtask

    task automatic model_reset();
        m_loading = 0; m_eop = 0; m_eov = 0; m_ptr = 0; m_cnt = 0;
    endtask

    // Entered one time unit after a rising edge; leaves one unit after the next one.
    task automatic tick();
        bit fin;
        #1;
        e_ready   = m_loading && !start;
        obs_ready = in_ready;
        e_wr = 0; e_done = 0;
        if (start) begin
            m_ptr = int'(start_addr); m_cnt = 0; m_eop = 0; m_eov = 0; m_loading = 1;
        end else if (in_valid && e_ready) begin
            fin = last;
            if (opcode <= 17) begin
                e_wr = 1; e_addr = m_ptr; e_data = ref_encode();
                if (!last && m_ptr == DEPTH - 1) begin
                    m_eov = 1; fin = 1;
                end
                m_ptr = (m_ptr + 1) % DEPTH;
                if (m_cnt < DEPTH) m_cnt++;
            end else begin
                m_eop = 1;
            end
            if (fin) begin
                m_loading = 0; e_done = 1;
            end
        end
        @(posedge clk);
        #1;
        exp_v = {e_ready, m_loading, e_wr, e_wr ? 6'(e_addr) : 6'd0, e_wr ? e_data : 32'd0,
                 e_done, m_eop, m_eov, 7'(m_cnt)};
        obs   = {obs_ready, busy, wr_en, e_wr ? wr_addr : 6'd0, e_wr ? wr_data : 32'd0,
                 done, err_opcode, err_overflow, word_count};
    endtask

    task automatic test_reset();
        reset = 1;
        #1;
        checks++;
        if ({in_ready, busy, wr_en, wr_addr, wr_data, done, err_opcode, err_overflow, word_count} !== 51'd0) begin
            failures++;
            $display("FAIL reset_state obs=%h exp=0", {in_ready, busy, wr_en, wr_addr, wr_data, done,
                     err_opcode, err_overflow, word_count});
        end
        @(posedge clk); #1;
        reset = 0;
        model_reset();
    endtask

    task automatic test_add();
        rand_fields(); start = 1; start_addr = 0; in_valid = 0;
        tick();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL add_start obs=%h exp=%h", obs, exp_v); end
        rand_fields(); cond = 4'hE; opcode = 5'b00100; immediateOperand = 1; CPSRwrite = 0;
        rn = 4'hD; rd = 4'hB; shifterVals = 12'h004;
        tick();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL add_write obs=%h exp=%h", obs, exp_v); end
        checks++;
        if ({wr_en, wr_addr, wr_data, word_count} !== {1'b1, 6'd0, 32'hE28DB004, 7'd1}) begin
            failures++;
            $display("FAIL add_word obs=%h exp=%h", {wr_en, wr_addr, wr_data, word_count},
                     {1'b1, 6'd0, 32'hE28DB004, 7'd1});
        end
    endtask

    task automatic test_back_to_back();
        rand_fields(); cond = 4'hE; opcode = 5'd16; immediateOperand = 0;
        {prePostAddOffset, upDownOffset, byteOrWord, writeBack, loadStore} = 5'b11001;
        rn = 4'hF; rd = 4'h0; shifterVals = 12'h014;
        tick();
        checks++;
        if ({wr_en, wr_addr, wr_data, done} !== {1'b1, 6'd1, 32'hE59F0014, 1'b0}) begin
            failures++; $display("FAIL ldr_word obs=%h exp=%h", {wr_en, wr_addr, wr_data, done},
                                 {1'b1, 6'd1, 32'hE59F0014, 1'b0});
        end
        rand_fields(); cond = 4'hE; opcode = 5'd17; linkBit = 1; branchImmediate = 24'hFFFFFE; last = 1;
        tick();
        checks++;
        if ({wr_en, wr_addr, wr_data, done} !== {1'b1, 6'd2, 32'hEBFFFFFE, 1'b1}) begin
            failures++; $display("FAIL bl_word obs=%h exp=%h", {wr_en, wr_addr, wr_data, done},
                                 {1'b1, 6'd2, 32'hEBFFFFFE, 1'b1});
        end
        rand_fields();
        tick();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL after_last obs=%h exp=%h", obs, exp_v); end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL ready_in_done obs=%b exp=0", in_ready); end
    endtask

    task automatic test_overflow();
        rand_fields(); start = 1; start_addr = 6'h3F; in_valid = 0;
        tick();
        rand_fields(); cond = 4'hE; opcode = 5'b01101; immediateOperand = 1; CPSRwrite = 0;
        rn = 4'h0; rd = 4'h3; shifterVals = 12'h000;
        tick();
        checks++;
        if ({wr_en, wr_addr, wr_data, err_overflow, done} !== {1'b1, 6'h3F, 32'hE3A03000, 1'b1, 1'b1}) begin
            failures++; $display("FAIL ovf_word obs=%h exp=%h", {wr_en, wr_addr, wr_data, err_overflow, done},
                                 {1'b1, 6'h3F, 32'hE3A03000, 1'b1, 1'b1});
        end
        for (int i = 0; i < 3; i++) begin
            rand_fields(); opcode = 5'd1;
            tick();
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL ovf_drain i=%0d obs=%h exp=%h", i, obs, exp_v); end
        end
        rand_fields(); start = 1; start_addr = 6'h3F; in_valid = 0;
        tick();
        rand_fields(); opcode = 5'd17; last = 1;
        tick();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL last_at_top obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_bad_opcode();
        logic [5:0] first_addr;
        rand_fields(); start = 1; start_addr = 6'h10; in_valid = 0;
        tick();
        rand_fields(); opcode = 5'd3;
        tick();
        rand_fields(); opcode = 5'b10110;
        tick();
        checks++;
        if (obs !== exp_v || wr_en !== 1'b0 || err_opcode !== 1'b1) begin
            failures++; $display("FAIL bad_op obs=%h exp=%h", obs, exp_v);
        end
        rand_fields(); opcode = 5'd16;
        tick();
        first_addr = wr_addr;
        checks++;
        if (obs !== exp_v || first_addr !== 6'h11) begin
            failures++; $display("FAIL bad_op_next obs=%h exp=%h addr=%h exp_addr=11", obs, exp_v, first_addr);
        end
    endtask

    task automatic test_reset_mid();
        rand_fields(); start = 1; start_addr = 6'h08; in_valid = 0;
        tick();
        rand_fields(); opcode = 5'b11111;
        tick();
        rand_fields(); opcode = 5'd5;
        tick();
        reset = 1;
        #1;
        checks++;
        if ({wr_en, busy, done, err_opcode, word_count} !== 11'd0) begin
            failures++; $display("FAIL reset_mid obs=%h exp=0", {wr_en, busy, done, err_opcode, word_count});
        end
        reset = 0;
        model_reset();
        rand_fields(); start = 1; start_addr = 6'h20; in_valid = 0;
        tick();
        rand_fields(); opcode = 5'd9;
        tick();
        checks++;
        if (obs !== exp_v || wr_addr !== 6'h20) begin
            failures++; $display("FAIL resume obs=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_start_during_load();
        rand_fields(); start = 1; start_addr = 6'h04; in_valid = 0;
        tick();
        for (int i = 0; i < 3; i++) begin rand_fields(); opcode = 5'd2; tick(); end
        rand_fields(); opcode = 5'd2; start = 1; start_addr = 6'h30;
        tick();
        checks++;
        if (obs !== exp_v || obs_ready !== 1'b0) begin
            failures++; $display("FAIL start_in_load obs=%h exp=%h", obs, exp_v);
        end
        rand_fields(); opcode = 5'd16;
        tick();
        checks++;
        if (obs !== exp_v || {wr_addr, word_count} !== {6'h30, 7'd1}) begin
            failures++; $display("FAIL restart_word obs=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rand_fields();
            in_valid   = ($urandom_range(0, 3) != 0);
            last       = ($urandom_range(0, 15) == 0);
            start      = (!m_loading && $urandom_range(0, 2) == 0) || ($urandom_range(0, 79) == 0);
            start_addr = 6'($urandom);
            tick();
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL random i=%0d obs=%h exp=%h", i, obs, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_overflow();
        test_bad_opcode();
        test_reset_mid();
        test_start_during_load();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
